// File: rtl/hubris_mmio_pkg.sv
// Shared MMIO definitions for the Hubris core's peripheral windows:
// register offsets and the bit positions inside the status word.
package hubris_mmio_pkg;

  localparam logic [3:0] IOBUF_TXDATA = 4'h0;
  localparam logic [3:0] IOBUF_STATUS = 4'h4;
  localparam logic [3:0] IOBUF_FREE   = 4'h8;

  localparam int EMPTY_BIT = 29;
  localparam int OVF_BIT   = 30;
  localparam int FULL_BIT  = 31;

  // Register selection only looks at the word index, so offsets 0x1..0x3
  // alias TXDATA, and so on.
  function automatic logic [3:0] word_offset(input logic [1:0] idx);
    return {idx, 2'b00};
  endfunction

endpackage

// File: rtl/io_output_buffer_if.sv
// Bus bundle between the core store path / console drain and the
// output buffer. The master side is the core plus the external consumer.
interface io_output_buffer_if;
  logic        mmio_sel;
  logic        mmio_wr_en;
  logic        mmio_rd_en;
  logic [3:0]  mmio_addr;
  logic [31:0] mmio_wdata;
  logic [3:0]  mmio_wstrb;
  logic [31:0] mmio_rdata;
  logic        io_output_en;
  logic [7:0]  io_output_data;
  logic [31:0] io_buffer_size_avai;

  modport master (
    output mmio_sel, mmio_wr_en, mmio_rd_en, mmio_addr, mmio_wdata, mmio_wstrb,
    output io_output_en,
    input  mmio_rdata, io_output_data, io_buffer_size_avai
  );

  modport slave (
    input  mmio_sel, mmio_wr_en, mmio_rd_en, mmio_addr, mmio_wdata, mmio_wstrb,
    input  io_output_en,
    output mmio_rdata, io_output_data, io_buffer_size_avai
  );
endinterface

// File: rtl/sync_fifo_fwft.sv
// Generic circular FIFO with first-word fall-through head. A push into a
// full FIFO is accepted only when a pop frees a slot in the same cycle.
module sync_fifo_fwft #(
  parameter  int DEPTH  = 16,
  parameter  int DATA_W = 8,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic              pop_ok;
  logic              push_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  // Storage array; contents survive reset, only the pointers are cleared.
  always_ff @(posedge clk) begin
    if (push_ok && !reset) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/io_output_buffer.sv
// Console transmit buffer: MMIO decode for TXDATA/STATUS/FREE, sticky
// overflow flag, registered read data, wrapped around a FWFT byte FIFO.
module io_output_buffer
  import hubris_mmio_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input logic clk,
  input logic reset,
  io_output_buffer_if.slave bus
);

  logic [3:0]       offset;
  logic             wr_cyc;
  logic             rd_cyc;
  logic             push_req;
  logic             clr_req;
  logic             ovf_set;
  logic             overflow;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic [31:0]      rd_word;
  logic             unused_bits;

  function automatic logic [31:0] status_word(input logic [CNT_W-1:0] cnt,
                                              input logic f, input logic e,
                                              input logic o);
    logic [31:0] w;
    w            = '0;
    w[CNT_W-1:0] = cnt;
    w[EMPTY_BIT] = e;
    w[OVF_BIT]   = o;
    w[FULL_BIT]  = f;
    return w;
  endfunction

  assign offset   = word_offset(bus.mmio_addr[3:2]);
  assign wr_cyc   = bus.mmio_sel & bus.mmio_wr_en;
  assign rd_cyc   = bus.mmio_sel & bus.mmio_rd_en;
  assign push_req = wr_cyc & (offset == IOBUF_TXDATA) & bus.mmio_wstrb[0];
  assign clr_req  = wr_cyc & (offset == IOBUF_STATUS) & bus.mmio_wstrb[3]
                  & bus.mmio_wdata[OVF_BIT];
  // A full FIFO always has data, so a pop request alone frees the slot.
  assign ovf_set  = push_req & full & ~bus.io_output_en;

  assign unused_bits = &{1'b0, bus.mmio_addr[1:0], bus.mmio_wdata[31],
                         bus.mmio_wdata[29:8], bus.mmio_wstrb[2:1]};

  sync_fifo_fwft #(.DEPTH(DEPTH), .DATA_W(8)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_req),
    .push_data (bus.mmio_wdata[7:0]),
    .pop       (bus.io_output_en),
    .head      (bus.io_output_data),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  assign bus.io_buffer_size_avai = 32'(count);

  // Sticky overflow; a new drop in the same cycle beats a software clear.
  always_ff @(posedge clk) begin
    if (reset)        overflow <= 1'b0;
    else if (ovf_set) overflow <= 1'b1;
    else if (clr_req) overflow <= 1'b0;
  end

  // Read mux built from the state before the sampling edge.
  always_comb begin
    rd_word = '0;
    case (offset)
      IOBUF_STATUS: rd_word = status_word(count, full, empty, overflow);
      IOBUF_FREE:   rd_word = 32'(CNT_W'(DEPTH) - count);
      default:      rd_word = '0;
    endcase
  end

  // Load data register; holds its value between loads.
  always_ff @(posedge clk) begin
    if (reset)       bus.mmio_rdata <= '0;
    else if (rd_cyc) bus.mmio_rdata <= rd_word;
  end

endmodule
